// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store data.
// Optional perf counters (perf_conflicts, perf_if_wait) are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned WIDTH        = 22,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_ready,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ready,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]      perf_conflicts,
  output logic [15:0]      perf_if_wait
`endif
);

  localparam int unsigned LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           r_state;
  logic             r_owner_d;
  logic             r_store;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_if_ready;
  logic             r_d_ready;
  logic [WIDTH-1:0] r_if_rdata;
  logic [WIDTH-1:0] r_d_rdata;
  logic             r_mem_en;
  logic             r_mem_we;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic             r_busy;

  logic w_starved;
  logic w_grant_d;
  logic w_grant_if;

  // Data wins conflicts unless fetch has lost STARVE_LIMIT times in a row
  assign w_starved  = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign w_grant_d  = d_req && !(if_req && w_starved);
  assign w_grant_if = if_req && !w_grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner_d    <= 1'b0;
      r_store      <= 1'b0;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_if_ready   <= 1'b0;
      r_d_ready    <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      r_mem_we   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d || w_grant_if) begin
            r_state     <= ACCESS;
            r_owner_d   <= w_grant_d;
            r_store     <= w_grant_d && d_we;
            r_lat_cnt   <= '0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_grant_d && d_we;
            r_mem_addr  <= w_grant_d ? d_addr : if_addr;
            r_mem_wdata <= w_grant_d ? d_wdata : '0;
            r_busy      <= 1'b1;
            if (w_grant_if)
              r_starve_cnt <= '0;
            else if (if_req && !w_starved)
              r_starve_cnt <= r_starve_cnt + CNT_W'(1);
          end
        end
        ACCESS: begin
          r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          if (r_lat_cnt == LAT_W'(MEM_LATENCY - 1)) begin
            r_state  <= RESP;
            r_mem_en <= 1'b0;
            if (r_owner_d) begin
              r_d_ready <= 1'b1;
              if (!r_store) r_d_rdata <= mem_rdata;
            end else begin
              r_if_ready <= 1'b1;
              r_if_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign if_ready  = r_if_ready;
  assign if_rdata  = r_if_rdata;
  assign d_ready   = r_d_ready;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] r_perf_conflicts;
  logic [15:0] r_perf_if_wait;

  // Saturating conflict and fetch-wait counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_conflicts <= '0;
      r_perf_if_wait   <= '0;
    end else begin
      if (r_state == IDLE && if_req && d_req && r_perf_conflicts != 16'hFFFF)
        r_perf_conflicts <= r_perf_conflicts + 16'd1;
      if (if_req && !r_if_ready && r_perf_if_wait != 16'hFFFF)
        r_perf_if_wait <= r_perf_if_wait + 16'd1;
    end
  end

  assign perf_conflicts = r_perf_conflicts;
  assign perf_if_wait   = r_perf_if_wait;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timing reference model.
module tb_mem_port_arbiter;
  localparam int unsigned W  = 22;
  localparam int unsigned L  = 2;
  localparam int unsigned SL = 3;

  typedef struct packed {
    logic         busy;
    logic         mem_en;
    logic         mem_we;
    logic         if_ready;
    logic         d_ready;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] if_rdata;
    logic [W-1:0] d_rdata;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic if_req, d_req, d_we;
  logic [W-1:0] if_addr, d_addr, d_wdata;
  logic if_ready, d_ready, mem_en, mem_we, busy;
  logic [W-1:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_conflicts, perf_if_wait;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(W), .MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_PERF_CNT_EN
    , .perf_conflicts(perf_conflicts), .perf_if_wait(perf_if_wait)
`endif
  );

  // Memory device: data valid only in the last cycle of the latency window, junk otherwise
  logic [W-1:0] tb_mem [logic [W-1:0]];
  int unsigned en_run = 0;

  function automatic logic [W-1:0] mem_read(input logic [W-1:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : (a ^ 22'h2A5A5A);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      en_run = 0;
      mem_rdata = W'($urandom);
    end else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] = mem_wdata;
      mem_rdata = (en_run == L - 1) ? mem_read(mem_addr) : W'($urandom);
      en_run++;
    end else begin
      en_run = 0;
      mem_rdata = W'($urandom);
    end
  end

  // Reference model state
  logic [W-1:0] ref_mem [logic [W-1:0]];
  bit           m_valid, m_owner_d, m_store;
  int           m_g, ec;
  int unsigned  m_starve;
  logic [W-1:0] m_addr, m_wdata;
  int unsigned  m_conf, m_ifwait;
  obs_t         exp_o;
  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;

  function automatic logic [W-1:0] ref_read(input logic [W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 22'h2A5A5A);
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.busy      = busy;
    o.mem_en    = mem_en;
    o.mem_we    = mem_we;
    o.if_ready  = if_ready;
    o.d_ready   = d_ready;
    o.mem_addr  = mem_en ? mem_addr : '0;
    o.mem_wdata = mem_we ? mem_wdata : '0;
    o.if_rdata  = if_rdata;
    o.d_rdata   = d_rdata;
    return o;
  endfunction

  function automatic logic [W-1:0] rand_addr();
    return ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 7)) : W'($urandom);
  endfunction

  // Advance one clock; the model sees the inputs present at the edge, then outputs are sampled at negedge
  task automatic step();
    bit active, gd, gf;
    int t;
    @(posedge clk);
    ec++;
    active = m_valid && (ec <= m_g + int'(L) + 1);
    if (if_req && !exp_o.if_ready && m_ifwait < 65535) m_ifwait++;
    if (!active) begin
      if (if_req && d_req && m_conf < 65535) m_conf++;
      gd = d_req && (!if_req || m_starve != SL);
      gf = if_req && !gd;
      if (gd || gf) begin
        m_valid   = 1'b1;
        m_g       = ec;
        m_owner_d = gd;
        m_store   = gd && d_we;
        m_addr    = gd ? d_addr : if_addr;
        m_wdata   = d_wdata;
        if (m_store) ref_mem[m_addr] = d_wdata;
        if (gf) m_starve = 0;
        else if (if_req && m_starve < SL) m_starve++;
      end else begin
        m_valid = 1'b0;
      end
    end
    t = ec - m_g;
    exp_o.busy      = m_valid && t <= int'(L);
    exp_o.mem_en    = m_valid && t < int'(L);
    exp_o.mem_we    = m_valid && t == 0 && m_store;
    exp_o.if_ready  = m_valid && t == int'(L) && !m_owner_d;
    exp_o.d_ready   = m_valid && t == int'(L) && m_owner_d;
    exp_o.mem_addr  = exp_o.mem_en ? m_addr : '0;
    exp_o.mem_wdata = exp_o.mem_we ? m_wdata : '0;
    if (m_valid && t == int'(L) && !m_store) begin
      if (m_owner_d) exp_o.d_rdata = ref_read(m_addr);
      else           exp_o.if_rdata = ref_read(m_addr);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    m_valid = 1'b0; m_starve = 0; m_conf = 0; m_ifwait = 0;
    exp_o = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({busy, if_ready, d_ready, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset: outputs got %h required 0",
               {busy, if_ready, d_ready, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata});
    end
  endtask

  task automatic test_fetch_read();
    int en_cycles = 0;
    int rdy_t = -1;
    tb_mem[22'h000010]  = 22'h2A5A5A;
    ref_mem[22'h000010] = 22'h2A5A5A;
    if_req = 1'b1; if_addr = 22'h000010;
    for (int i = 0; i < int'(L) + 3; i++) begin
      step();
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL fetch_read cyc %0d: got %h required %h", i, observe(), exp_o);
      end
      if (mem_en) en_cycles++;
      if (if_ready) begin rdy_t = i; if_req = 1'b0; end
    end
    vectors++;
    if (if_rdata !== 22'h2A5A5A || rdy_t != int'(L) || en_cycles != int'(L)) begin
      miscompares++;
      $display("FAIL fetch_result: rdata %h ready_t %0d en %0d required 2a5a5a %0d %0d",
               if_rdata, rdy_t, en_cycles, L, L);
    end
  endtask

  task automatic test_store();
    int we_cycles = 0;
    int rdy = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 22'h000100; d_wdata = 22'h00BEEF;
    for (int i = 0; i < int'(L) + 3; i++) begin
      step();
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL store cyc %0d: got %h required %h", i, observe(), exp_o);
      end
      if (mem_we) begin
        we_cycles++;
        vectors++;
        if (mem_addr !== 22'h000100 || i != 0) begin
          miscompares++;
          $display("FAIL store_we: addr %h at cyc %0d required 000100 at 0", mem_addr, i);
        end
      end
      if (d_ready) begin rdy++; d_req = 1'b0; d_we = 1'b0; end
    end
    vectors++;
    if (we_cycles != 1 || rdy != 1 || d_rdata !== 22'h0 || mem_read(22'h000100) !== 22'h00BEEF) begin
      miscompares++;
      $display("FAIL store_result: we %0d rdy %0d d_rdata %h mem %h required 1 1 0 00beef",
               we_cycles, rdy, d_rdata, mem_read(22'h000100));
    end
  endtask

  task automatic test_starvation();
    string order = "";
    int n = 0;
    do_reset();
    if_req = 1'b1; if_addr = 22'h000200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 22'h000300;
    for (int i = 0; i < 80 && n < 8; i++) begin
      step();
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL starve cyc %0d: got %h required %h", i, observe(), exp_o);
      end
      if (d_ready)  begin order = {order, "D"}; n++; d_addr = d_addr + 22'd1; end
      if (if_ready) begin order = {order, "F"}; n++; if_addr = if_addr + 22'd1; end
    end
    if_req = 1'b0; d_req = 1'b0;
    vectors++;
    if (order != "DDDFDDDF") begin
      miscompares++;
      $display("FAIL starve_order: got %s required DDDFDDDF", order);
    end
  endtask

  task automatic test_addr_change();
    int rdy = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 22'h000055;
    for (int i = 0; i < int'(L) + 4; i++) begin
      step();
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL addr_change cyc %0d: got %h required %h", i, observe(), exp_o);
      end
      if (mem_en && mem_addr !== 22'h000055) begin
        miscompares++;
        $display("FAIL addr_latch: mem_addr %h required 000055", mem_addr);
      end
      if (busy) d_addr = 22'h3FFFFF;
      if (d_ready) begin rdy++; d_req = 1'b0; end
    end
    vectors++;
    if (rdy != 1 || d_rdata !== (22'h000055 ^ 22'h2A5A5A)) begin
      miscompares++;
      $display("FAIL addr_change_result: rdy %0d d_rdata %h required 1 %h", rdy, d_rdata,
               22'h000055 ^ 22'h2A5A5A);
    end
  endtask

  task automatic test_reset_mid();
    int rdy = 0;
    if_req = 1'b1; if_addr = 22'h000033;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, if_ready, d_ready, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: outputs got %h required 0",
               {busy, if_ready, d_ready, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL reset_quiet cyc %0d: got %h required %h", i, observe(), exp_o);
      end
    end
    if_req = 1'b1; if_addr = 22'h000034;
    for (int i = 0; i < int'(L) + 3; i++) begin
      step();
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL reset_recover cyc %0d: got %h required %h", i, observe(), exp_o);
      end
      if (if_ready) begin rdy++; if_req = 1'b0; end
    end
    vectors++;
    if (rdy != 1) begin
      miscompares++;
      $display("FAIL reset_recover_ready: count %0d required 1", rdy);
    end
  endtask

  task automatic test_random();
    bit own_if, own_d;
    for (int c = 0; c < 400; c++) begin
      step();
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h required %h", c, observe(), exp_o);
      end
`ifdef ARB_PERF_CNT_EN
      vectors++;
      if (perf_conflicts !== 16'(m_conf) || perf_if_wait !== 16'(m_ifwait)) begin
        miscompares++;
        $display("FAIL random_perf cyc %0d: got %0d/%0d required %0d/%0d", c,
                 perf_conflicts, perf_if_wait, m_conf, m_ifwait);
      end
`endif
      own_if = m_valid && !m_owner_d && (ec - m_g) < int'(L);
      own_d  = m_valid &&  m_owner_d && (ec - m_g) < int'(L);
      if (own_if && $urandom_range(0, 3) == 0) begin
        if_addr = W'($urandom);
        if_req  = 1'($urandom_range(0, 1));
      end else if (!own_if && (exp_o.if_ready || !if_req)) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = rand_addr();
      end
      if (own_d && $urandom_range(0, 3) == 0) begin
        d_addr  = W'($urandom);
        d_wdata = W'($urandom);
        d_we    = 1'($urandom_range(0, 1));
        d_req   = 1'($urandom_range(0, 1));
      end else if (!own_d && (exp_o.d_ready || !d_req)) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = rand_addr();
        d_wdata = W'($urandom);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int c = 0; c < int'(L) + 2; c++) begin
      step();
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL random_drain cyc %0d: got %h required %h", c, observe(), exp_o);
      end
    end
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf();
    int n = 0;
    do_reset();
    if_req = 1'b1; if_addr = 22'h000400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 22'h000500;
    for (int i = 0; i < 40 && n < 4; i++) begin
      step();
      if (d_ready || if_ready) n++;
      if (n == 4) begin if_req = 1'b0; d_req = 1'b0; end
    end
    step();
    vectors++;
    if (perf_conflicts !== 16'd4 || perf_if_wait !== 16'(m_ifwait)) begin
      miscompares++;
      $display("FAIL perf: conflicts %0d if_wait %0d required 4 %0d",
               perf_conflicts, perf_if_wait, m_ifwait);
    end
  endtask
`endif

  initial begin
    ec = 0;
    m_g = 0;
    test_reset();
    test_fetch_read();
    test_store();
    test_starvation();
    test_addr_change();
    test_reset_mid();
    test_random();
`ifdef ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
